// File: rtl/lcd_frame_arbiter.sv
// Round-robin owner of the 16x2 character LCD among NREQ frame sources.
// Each grant is protected from preemption for DWELL_CYC cycles; idle shows a blank frame.
//
// state  | meaning
// S_IDLE | no owner, blank frame on chars
// S_HOLD | one source owns the display, its frame passes through live
module lcd_frame_arbiter #(
    parameter int         NREQ       = 2,
    parameter int         DWELL_CYC  = 50_000_000,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*256-1:0]  frame_in,
    output logic [NREQ-1:0]      gnt,
    output logic [255:0]         chars,
    output logic                 busy,
    output logic                 switch_pulse
);

    localparam int              CW       = $clog2(DWELL_CYC + 1);
    localparam int              LW       = $clog2(NREQ);
    localparam int              LW1      = LW + 1;
    localparam logic            S_IDLE   = 1'b0;
    localparam logic            S_HOLD   = 1'b1;
    localparam logic [255:0]    BLANK    = {32{BLANK_CHAR}};
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL_CYC - 1);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    logic           state;
    logic [CW-1:0]  cnt;
    logic [LW-1:0]  last;
    logic [LW-1:0]  win;
    logic [LW1-1:0] idx;
    logic           found;
    logic           any_req;
    logic           release_evt;
    logic [255:0]   frames [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_frames
        assign frames[g] = frame_in[g*256 +: 256];
    end

    // Scan last+1, last+2, ... wrapping; the current owner is visited last.
    always_comb begin
        win   = last;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = {1'b0, last} + LW1'(i);
            if (idx >= LW1'(NREQ)) begin
                idx = idx - LW1'(NREQ);
            end
            if (!found && req[idx[LW-1:0]]) begin
                found = 1'b1;
                win   = idx[LW-1:0];
            end
        end
    end

    assign any_req     = |req;
    assign release_evt = (cnt == CNT_LAST) || !req[last];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            gnt          <= '0;
            chars        <= BLANK;
            busy         <= 1'b0;
            switch_pulse <= 1'b0;
            cnt          <= '0;
            last         <= LW'(NREQ - 1);
        end else begin
            switch_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state        <= S_HOLD;
                        gnt          <= ONE << win;
                        busy         <= 1'b1;
                        last         <= win;
                        chars        <= frames[win];
                        cnt          <= '0;
                        switch_pulse <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (release_evt && !any_req) begin
                        state <= S_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        chars <= BLANK;
                        cnt   <= '0;
                    end else if (release_evt && (win != last)) begin
                        gnt          <= ONE << win;
                        last         <= win;
                        chars        <= frames[win];
                        cnt          <= '0;
                        switch_pulse <= 1'b1;
                    end else if (release_evt) begin
                        // sole requester at expiry keeps the display, fresh dwell
                        chars <= frames[last];
                        cnt   <= '0;
                    end else begin
                        chars <= frames[last];
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    chars <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
